pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush/hold sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards in ID.
- Redirects and flushes on a taken branch resolved in MEM.
- Freezes the pipe while a multi-cycle data-memory access is pending, with a timeout watchdog.
- Sits beside the pipeline registers; drives their write-enable, flush and hold inputs, plus the PC mux select.

Parameters:
MEM_TIMEOUT, 64, max cycles spent in MEM_WAIT before the access is abandoned (range 2..255)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
IF_ID_rs1  in  5  source register 1 of the instruction in ID
IF_ID_rs2  in  5  source register 2 of the instruction in ID
IF_ID_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
ID_EX_rd  in  5  destination of the instruction in EX
ID_EX_MemRead  in  1  EX instruction is a load
EX_MEM_Branch  in  1  MEM instruction is a branch
EX_MEM_ALUzero  in  1  branch condition true
EX_MEM_MemRead  in  1  MEM instruction is a load
EX_MEM_MemWrite  in  1  MEM instruction is a store
dmem_ready  in  1  data memory completes the access this cycle
PCWrite  out  1  PC register enable
PCSrc  out  1  1 = select branch target (EX_MEM_adder2out)
IF_ID_Write  out  1  IF/ID enable
IF_ID_flush  out  1  zero IF/ID at next edge
ID_EX_flush  out  1  zero ID/EX at next edge (bubble)
ID_EX_hold  out  1  ID/EX keeps its value
EX_MEM_flush  out  1  zero EX/MEM at next edge
EX_MEM_hold  out  1  EX/MEM keeps its value
MEM_WB_flush  out  1  insert bubble into MEM/WB
dmem_req  out  1  data-memory access request
ctrl_state  out  2  00 RUN, 01 MEM_WAIT, 10 FLUSH
timeout_err  out  1  sticky; set when a memory access times out
stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  performance counters (see Optional Feature)

Behaviour:
- Registered state: state, wait_cnt (8 bit), timeout_err.
- All other control outputs are combinational from state and inputs, so they take effect at the next clock edge.
- While reset is low: state=RUN, wait_cnt=0, timeout_err=0. Control outputs are PCWrite=0, IF_ID_Write=0 and all other outputs 0.
- Default (RUN, no event): PCWrite=1, IF_ID_Write=1; all flush/hold=0; PCSrc=0.
- Event definitions:
  - taken = EX_MEM_Branch & EX_MEM_ALUzero.
  - memop = EX_MEM_MemRead | EX_MEM_MemWrite.
  - lduse = ID_EX_MemRead & (ID_EX_rd != 0) & ((ID_EX_rd == IF_ID_rs1) | (IF_ID_uses_rs2 & ID_EX_rd == IF_ID_rs2)).
- Priority in RUN: taken > memop-wait > lduse.
- RUN, taken:
  - PCSrc=1, PCWrite=1.
  - IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=1.
  - Next state FLUSH.
- RUN, memop:
  - dmem_req=1.
  - If dmem_ready is also 1: zero-wait, treated as default.
  - Otherwise: PCWrite=0, IF_ID_Write=0, ID_EX_hold=1, EX_MEM_hold=1, MEM_WB_flush=1; next state MEM_WAIT, wait_cnt=1.
- RUN, lduse: PCWrite=0, IF_ID_Write=0, ID_EX_flush=1 (exactly one bubble); state stays RUN.
- MEM_WAIT:
  - dmem_req=1, full freeze as above.
  - lduse and taken are ignored.
  - dmem_ready=1: release the freeze this cycle (default outputs, lduse honoured); next state RUN, wait_cnt=0.
  - Else if wait_cnt == MEM_TIMEOUT-1: set timeout_err, drop dmem_req next cycle, EX_MEM_flush=1 (abandon access), next state RUN.
  - Else wait_cnt += 1.
- FLUSH:
  - Lasts one cycle; outputs are default.
  - lduse is masked, because ID/EX holds a bubble.
  - taken cannot occur, because EX/MEM was zeroed.
  - Next state RUN.
- timeout_err clears only on reset.
- Asserting reset mid-MEM_WAIT: state returns to RUN asynchronously and dmem_req drops immediately.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: three CNT_W-bit saturating counters (reset 0):
  - stall_cnt increments on each lduse stall cycle.
  - flush_cnt increments on each taken branch.
  - memwait_cnt increments on each MEM_WAIT cycle.
- Not defined: the counter ports remain but are tied to 0; no counter flops are built.

Test Plan:
- Load-use hazard. Stimulus: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs1=5. Response: for exactly 1 cycle, PCWrite=0, IF_ID_Write=0, ID_EX_flush=1. The same stimulus with ID_EX_rd=0 gives no stall.
- rs2 qualification. Stimulus: IF_ID_rs2 matches ID_EX_rd with IF_ID_uses_rs2=0. Response: no stall. With IF_ID_uses_rs2=1: stall.
- Taken branch with simultaneous load-use. Stimulus: EX_MEM_Branch=1, EX_MEM_ALUzero=1 while a load-use condition is also true. Response: PCSrc=1, all three flushes=1, no stall; ctrl_state=10 for 1 cycle, then 00.
- Load wait. Stimulus: EX_MEM_MemRead=1, dmem_ready low for 3 cycles then high. Response: freeze (holds=1, PCWrite=0) for 3 cycles; ctrl_state=01 for 3 cycles; release on the ready cycle.
- Timeout. Stimulus: MEM_TIMEOUT=4, dmem_ready held 0. Response: timeout_err=1 after 4 cycles, EX_MEM_flush pulse, return to RUN. Reset low mid-wait: timeout_err=0, dmem_req=0 immediately.
- With HAZARD_PERF_CNT_EN defined. Stimulus: 2 stalls, 1 branch, 3 wait cycles. Response: stall_cnt=2, flush_cnt=1, memwait_cnt=3. Without the macro, all three counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/hold sequencer for the 5-stage pipeline registers, with a memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_ALUzero,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IF_ID_Write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             ID_EX_hold,
    output logic             EX_MEM_flush,
    output logic             EX_MEM_hold,
    output logic             MEM_WB_flush,
    output logic             dmem_req,
    output logic [1:0]       ctrl_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       timeout_err_reg, timeout_err_next;

    logic taken, memop, lduse;
    logic stall_ev, flush_ev, memwait_ev;

    assign taken = EX_MEM_Branch & EX_MEM_ALUzero;
    assign memop = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign lduse = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                   ((ID_EX_rd == IF_ID_rs1) || (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        timeout_err_next = timeout_err_reg;
        PCWrite          = 1'b0;
        PCSrc            = 1'b0;
        IF_ID_Write      = 1'b0;
        IF_ID_flush      = 1'b0;
        ID_EX_flush      = 1'b0;
        ID_EX_hold       = 1'b0;
        EX_MEM_flush     = 1'b0;
        EX_MEM_hold      = 1'b0;
        MEM_WB_flush     = 1'b0;
        dmem_req         = 1'b0;
        stall_ev         = 1'b0;
        flush_ev         = 1'b0;

        // Outputs stay at zero for as long as reset is held low.
        if (reset) begin
            case (state_reg)
                RUN: begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                    if (taken) begin
                        PCSrc        = 1'b1;
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        EX_MEM_flush = 1'b1;
                        flush_ev     = 1'b1;
                        state_next   = FLUSH;
                    end else if (memop && !dmem_ready) begin
                        dmem_req      = 1'b1;
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_hold    = 1'b1;
                        EX_MEM_hold   = 1'b1;
                        MEM_WB_flush  = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = 8'd1;
                    end else begin
                        dmem_req = memop;
                        if (lduse) begin
                            PCWrite     = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_flush = 1'b1;
                            stall_ev    = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        PCWrite       = 1'b1;
                        IF_ID_Write   = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = 8'd0;
                        if (lduse) begin
                            PCWrite     = 1'b0;
                            IF_ID_Write = 1'b0;
                            ID_EX_flush = 1'b1;
                            stall_ev    = 1'b1;
                        end
                    end else begin
                        ID_EX_hold   = 1'b1;
                        EX_MEM_hold  = 1'b1;
                        MEM_WB_flush = 1'b1;
                        if (wait_cnt_reg == WAIT_LAST) begin
                            // Abandon the access: the stuck instruction is dropped from EX/MEM.
                            EX_MEM_hold      = 1'b0;
                            EX_MEM_flush     = 1'b1;
                            timeout_err_next = 1'b1;
                            state_next       = RUN;
                            wait_cnt_next    = 8'd0;
                        end else begin
                            wait_cnt_next = wait_cnt_reg + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                    state_next  = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign memwait_ev  = reset && (state_reg == MEM_WAIT);
    assign ctrl_state  = state_reg;
    assign timeout_err = timeout_err_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0]            cnt_inc;
    logic [2:0][CNT_W-1:0] cnt_bus;

    assign cnt_inc = {memwait_ev, flush_ev, stall_ev};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign cnt_bus[gi] = cnt_reg;
    end

    assign stall_cnt   = cnt_bus[0];
    assign flush_cnt   = cnt_bus[1];
    assign memwait_cnt = cnt_bus[2];
`else
    logic unused_ev;
    assign unused_ev   = stall_ev ^ flush_ev ^ memwait_ev;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues expected control words, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // Control word bit layout used by the scoreboard.
    localparam logic [12:0] O_PCW = 13'h1000;
    localparam logic [12:0] O_PCS = 13'h0800;
    localparam logic [12:0] O_IFW = 13'h0400;
    localparam logic [12:0] O_IFF = 13'h0200;
    localparam logic [12:0] O_IDF = 13'h0100;
    localparam logic [12:0] O_IDH = 13'h0080;
    localparam logic [12:0] O_EXF = 13'h0040;
    localparam logic [12:0] O_EXH = 13'h0020;
    localparam logic [12:0] O_WBF = 13'h0010;
    localparam logic [12:0] O_REQ = 13'h0008;
    localparam logic [12:0] ST_F  = 13'h0004;
    localparam logic [12:0] ST_W  = 13'h0002;
    localparam logic [12:0] O_TE  = 13'h0001;
    localparam logic [12:0] DEFV   = O_PCW | O_IFW;
    localparam logic [12:0] FREEZE = O_REQ | O_IDH | O_EXH | O_WBF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic IF_ID_uses_rs2, ID_EX_MemRead, EX_MEM_Branch, EX_MEM_ALUzero;
    logic EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
    logic PCWrite, PCSrc, IF_ID_Write, IF_ID_flush, ID_EX_flush, ID_EX_hold;
    logic EX_MEM_flush, EX_MEM_hold, MEM_WB_flush, dmem_req, timeout_err;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_uses_rs2(IF_ID_uses_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_ALUzero(EX_MEM_ALUzero),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IF_ID_Write(IF_ID_Write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .ID_EX_hold(ID_EX_hold),
        .EX_MEM_flush(EX_MEM_flush), .EX_MEM_hold(EX_MEM_hold), .MEM_WB_flush(MEM_WB_flush),
        .dmem_req(dmem_req), .ctrl_state(ctrl_state), .timeout_err(timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    wire [12:0] obs = {PCWrite, PCSrc, IF_ID_Write, IF_ID_flush, ID_EX_flush, ID_EX_hold,
                       EX_MEM_flush, EX_MEM_hold, MEM_WB_flush, dmem_req, ctrl_state, timeout_err};

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            n_cmp++;
            if (obs !== mon_e.v) begin
                n_bad++;
                $display("FAIL %s: got %013b want %013b", mon_e.name, obs, mon_e.v);
            end else begin
                $display("ok   %s: %013b", mon_e.name, obs);
            end
        end
    end

    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic idmr,
                        input logic br, input logic z, input logic mr, input logic mw,
                        input logic rdy, input logic [12:0] ev, input string nm);
        @(posedge clk);
        #1;
        reset           = rst;
        IF_ID_rs1       = rs1;
        IF_ID_rs2       = rs2;
        IF_ID_uses_rs2  = u2;
        ID_EX_rd        = rd;
        ID_EX_MemRead   = idmr;
        EX_MEM_Branch   = br;
        EX_MEM_ALUzero  = z;
        EX_MEM_MemRead  = mr;
        EX_MEM_MemWrite = mw;
        dmem_ready      = rdy;
        q.push_back('{v: ev, name: nm});
    endtask

    task automatic check_cnt(input string nm, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end else begin
            $display("ok   %s: %0d", nm, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        {IF_ID_rs1, IF_ID_rs2, ID_EX_rd} = '0;
        {IF_ID_uses_rs2, ID_EX_MemRead, EX_MEM_Branch, EX_MEM_ALUzero} = '0;
        {EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready} = '0;

        //    rst rs1 rs2 u2 rd idmr br z mr mw rdy expected
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 13'h0,                 "reset_state");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV,                  "run_idle");
        step(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, O_IDF,                 "lduse_rs1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV,                  "lduse_one_cycle");
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, DEFV,                  "lduse_rd0");
        step(1, 1, 7, 0, 7, 1, 0, 0, 0, 0, 0, DEFV,                  "rs2_unused");
        step(1, 1, 7, 1, 7, 1, 0, 0, 0, 0, 0, O_IDF,                 "rs2_used");
        step(1, 5, 0, 0, 5, 1, 1, 1, 0, 0, 0,
             O_PCW | O_PCS | O_IFW | O_IFF | O_IDF | O_EXF,          "taken_over_lduse");
        step(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, DEFV | ST_F,           "flush_masks_lduse");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV,                  "flush_to_run");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, DEFV,                  "branch_not_taken");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, DEFV | O_REQ,          "load_zero_wait");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE,                "load_wait_0");
        step(1, 5, 0, 0, 5, 1, 1, 1, 1, 0, 0, FREEZE | ST_W,         "load_wait_1_ignores");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE | ST_W,         "load_wait_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, DEFV | O_REQ | ST_W,   "load_release");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV,                  "after_release");

        @(negedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check_cnt("stall_cnt", stall_cnt, 2);
        check_cnt("flush_cnt", flush_cnt, 1);
        check_cnt("memwait_cnt", memwait_cnt, 3);
`else
        check_cnt("stall_cnt", stall_cnt, 0);
        check_cnt("flush_cnt", flush_cnt, 0);
        check_cnt("memwait_cnt", memwait_cnt, 0);
`endif

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE,                "tmo_wait_0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE | ST_W,         "tmo_wait_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE | ST_W,         "tmo_wait_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
             O_REQ | O_IDH | O_WBF | O_EXF | ST_W,                   "tmo_abandon");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV | O_TE,           "tmo_sticky_run");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE | O_TE,         "wait2_enter");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FREEZE | ST_W | O_TE,  "wait2_mid");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 13'h0,                 "reset_mid_wait");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEFV,                  "after_reset");

        for (int i = 0; i < 5 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
